// File: rtl/alu_register.sv
// alu_register: eight-operation ALU whose result is captured in an output
// register, so result_o is valid one clock after operands/opcode are presented.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-low reset; clears result_o
//   first_i   operand A (value that is shifted, compared or negated)
//   second_i  operand B (shift amount for the shift opcodes)
//   opcode_i  operation select
//   result_o  registered result
//
// Opcodes: 000 NAND, 001 XOR, 010 ADD, 011 ASR, 100 OR, 101 LSL, 110 NOT, 111 LT
module alu_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] second_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] result_o
);

  // WIDTH always fits in WIDTH bits for WIDTH >= 2.
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] sign_fill;
  logic             shift_big;

  // The full operand B is compared against WIDTH so that large shift amounts
  // saturate instead of wrapping through the low bits.
  assign shift_big = (second_i >= WIDTH_V);
  assign sign_fill = {WIDTH{first_i[WIDTH-1]}};

  always_comb begin
    alu_next = '0;
    case (opcode_i)
      3'b000: alu_next = ~(first_i & second_i);
      3'b001: alu_next = first_i ^ second_i;
      3'b010: alu_next = first_i + second_i;
      3'b011: alu_next = shift_big ? sign_fill
                                   : $unsigned($signed(first_i) >>> second_i);
      3'b100: alu_next = first_i | second_i;
      3'b101: alu_next = shift_big ? '0 : (first_i << second_i);
      3'b110: alu_next = ~first_i;
      3'b111: alu_next = {{(WIDTH-1){1'b0}}, (first_i < second_i)};
      default: alu_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_o <= '0;
    end else begin
      result_o <= alu_next;
    end
  end

endmodule

// File: tb/tb_alu_register.sv
// tb_alu_register: directed test of alu_register (WIDTH = 8).
// A behavioural model predicts result_o from the inputs seen at each rising
// edge; a compare process checks the DUT against it on every falling edge.
// Directed vectors additionally carry hand-computed expected values.
module tb_alu_register;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] first_i = '0;
  logic [W-1:0] second_i = '0;
  logic [2:0]   opcode_i = '0;
  logic [W-1:0] result_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q = '0;

  alu_register #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .first_i (first_i),
    .second_i(second_i),
    .opcode_i(opcode_i),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Arithmetic description of each operation on plain integers.
  function automatic logic [W-1:0] model(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ua, ub, sa, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    case (op)
      3'd0: r = 255 - (ua & ub);
      3'd1: r = ua ^ ub;
      3'd2: r = (ua + ub) % 256;
      3'd3: r = (ub >= W) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
      3'd4: r = ua | ub;
      3'd5: r = (ub >= W) ? 0 : ((ua * (1 << ub)) % 256);
      3'd6: r = 255 - ua;
      default: r = (ua < ub) ? 1 : 0;
    endcase
    return r[W-1:0];
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) exp_q = '0;
    else        exp_q = model(opcode_i, first_i, second_i);
  end

  always @(negedge clk_i) begin
    checks++;
    if (result_o !== exp_q) begin
      errors++;
      $display("FAIL model_cmp t=%0t op=%0d a=%h b=%h got=%h want=%h",
               $time, opcode_i, first_i, second_i, result_o, exp_q);
    end
  end

  task automatic check(input string name, input logic [W-1:0] want);
    checks++;
    if (result_o !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, result_o, want);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] want);
    @(negedge clk_i);
    opcode_i = op;
    first_i  = a;
    second_i = b;
    @(posedge clk_i);
    #1;
    check(name, want);
  endtask

  initial begin
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("reset_hold", 8'h00);
    @(negedge clk_i);
    rst_i = 1'b1;

    do_op("nand",      3'b000, 8'hAA, 8'hCC, 8'h77);
    do_op("xor",       3'b001, 8'hF0, 8'hAA, 8'h5A);
    do_op("or",        3'b100, 8'h33, 8'h55, 8'h77);
    do_op("not",       3'b110, 8'h55, 8'h00, 8'hAA);
    do_op("add",       3'b010, 8'd100, 8'd50, 8'h96);
    do_op("add_wrap",  3'b010, 8'hFF, 8'h01, 8'h00);
    do_op("asr_2",     3'b011, 8'h99, 8'd2, 8'hE6);
    do_op("asr_7",     3'b011, 8'h80, 8'd7, 8'hFF);
    do_op("asr_9",     3'b011, 8'h80, 8'd9, 8'hFF);
    do_op("asr_pos",   3'b011, 8'h40, 8'd1, 8'h20);
    do_op("asr_big",   3'b011, 8'h7F, 8'd255, 8'h00);
    do_op("lsl_2",     3'b101, 8'h0F, 8'd2, 8'h3C);
    do_op("lsl_8",     3'b101, 8'h0F, 8'd8, 8'h00);
    do_op("lsl_big",   3'b101, 8'hFF, 8'd200, 8'h00);
    do_op("lsl_0",     3'b101, 8'h5A, 8'd0, 8'h5A);
    do_op("asr_0",     3'b011, 8'h5A, 8'd0, 8'h5A);
    do_op("lt_true",   3'b111, 8'd50, 8'd100, 8'h01);
    do_op("lt_false",  3'b111, 8'd100, 8'd50, 8'h00);
    do_op("lt_equal",  3'b111, 8'h7F, 8'h7F, 8'h00);
    do_op("lt_unsign", 3'b111, 8'h80, 8'h01, 8'h00);

    // Inputs changed between edges must not disturb the registered result.
    do_op("lat_first", 3'b001, 8'hF0, 8'h0F, 8'hFF);
    opcode_i = 3'b010;
    first_i  = 8'h01;
    second_i = 8'h01;
    #2 check("lat_hold", 8'hFF);
    @(posedge clk_i);
    #1 check("lat_next", 8'h02);

    // Reset asserted between edges clears the output without a clock edge.
    do_op("pre_reset", 3'b111, 8'd50, 8'd100, 8'h01);
    #2 rst_i = 1'b0;
    #1 check("async_rst", 8'h00);
    @(negedge clk_i);
    rst_i = 1'b1;
    opcode_i = 3'b100;
    first_i  = 8'h0F;
    second_i = 8'hF0;
    #2 check("rst_release_hold", 8'h00);
    @(posedge clk_i);
    #1 check("post_reset", 8'hFF);

    do_op("post_add",  3'b010, 8'h12, 8'h34, 8'h46);
    @(negedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_register.md
Name: alu_register

Overview:
- Parameterised 8-operation combinational ALU whose result is captured in an output register.
- result_o is valid one clock after the operands and opcode are presented.
- Used as a registered compute stage: operands come from upstream logic, and result_o feeds downstream synchronous logic.

Parameters:
- WIDTH, 8: bit width of both operands and of the result (WIDTH >= 2).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low; clears result_o.
- first_i  input  WIDTH  operand A; the shifted/compared/negated value.
- second_i  input  WIDTH  operand B; the shift amount for the shift opcodes.
- opcode_i  input  3  operation select.
- result_o  output  WIDTH  registered ALU result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - rst_i low clears result_o to 0 immediately, with no clock edge required.
  - result_o holds 0 while rst_i is low.
  - On the first rising edge after rst_i goes high, result_o loads the normal ALU result.
- Latency and timing:
  - On each rising clk_i with rst_i high, result_o <= f(opcode_i, first_i, second_i), sampled at that edge.
  - Latency is exactly 1 cycle; no handshake, no enable; a new operation is accepted every cycle.
  - Between edges result_o is stable regardless of input changes.
- Opcodes (A = first_i, B = second_i, all results truncated to WIDTH):
  - 000 NAND: ~(A & B).
  - 001 XOR: A ^ B.
  - 010 ADD: (A + B) mod 2^WIDTH; carry discarded, no flags.
  - 011 ASR: A shifted right by B bits, vacated MSBs filled with A[WIDTH-1]. If B >= WIDTH, result is all copies of A[WIDTH-1].
  - 100 OR: A | B.
  - 101 LSL: A shifted left by B bits, zero-filled. If B >= WIDTH, result is 0.
  - 110 NOT: ~A; B is ignored.
  - 111 LT: unsigned compare; 1 (zero-extended to WIDTH) if A < B, else 0. A == B gives 0.
- Shift amount:
  - The full B value is used, not only its low log2(WIDTH) bits.
  - B = 0 returns A unchanged for both shifts.
- No X propagation from unused operands; every opcode value is defined.
- Reset asserted mid-stream: result_o goes to 0 asynchronously and the in-flight result is discarded.

Test Plan:
- Reset and logic ops: hold rst_i low for 2 cycles, check result_o = 00. Release reset, then one op per cycle, checking after each edge:
  - NAND AA,CC -> 77
  - XOR F0,AA -> 5A
  - OR 33,55 -> 77
  - NOT 55 (B=0) -> AA
- ADD: 100+50 -> 150 (0x96); FF+01 -> 00 (wrap, carry dropped).
- ASR and LSL:
  - ASR 99 by 2 -> E6
  - ASR 80 by 7 -> FF
  - ASR 80 by 9 -> FF
  - ASR 40 by 1 -> 20
  - LSL 0F by 2 -> 3C
  - LSL 0F by 8 -> 00
  - LSL/ASR of 5A by 0 -> 5A
- LT:
  - 50<100 -> 01
  - 100<50 -> 00
  - 7F<7F -> 00
  - 80 vs 01 (unsigned) -> 00
- Latency: change opcode/operands mid-cycle (away from the edge) -> result_o unchanged until the next rising edge, then reflects the new operation.
- Asynchronous reset: after LT produced 01, drive rst_i low between edges -> result_o = 00 within the same half-cycle, before any clock edge. Release reset -> next edge restores normal operation.
